// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter with a valid/ready handshake on both sides.
// The output stage records whether each result differs from the last one, and can drop repeated results.
module gray_codec_pipe #(
  parameter int WIDTH       = 8,
  parameter int STAGES      = 2,
  parameter int CHANGE_ONLY = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_changed,
  output logic             out_first,
  output logic [CNT_W-1:0] drop_cnt
);

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Stage registers; index STAGES-1 is the output register.
  logic             stg_valid_reg [STAGES];
  logic             stg_mode_reg  [STAGES];
  logic [WIDTH-1:0] stg_data_reg  [STAGES];

  // What each stage would load on an advance.
  logic             feed_valid [STAGES];
  logic             feed_mode  [STAGES];
  logic [WIDTH-1:0] feed_data  [STAGES];

  logic             changed_reg;
  logic             first_reg;
  logic             seen_reg;
  logic [WIDTH-1:0] ref_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  logic adv;

  // One global stall: nothing moves while the output holds an unconsumed word.
  assign adv      = !stg_valid_reg[STAGES-1] | out_ready;
  assign in_ready = adv;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_feed_in
        assign feed_valid[gi] = in_valid & adv;
        assign feed_mode[gi]  = in_mode;
        assign feed_data[gi]  = in_mode ? gray_to_bin(in_data) : bin_to_gray(in_data);
      end else begin : g_feed_prev
        assign feed_valid[gi] = stg_valid_reg[gi-1];
        assign feed_mode[gi]  = stg_mode_reg[gi-1];
        assign feed_data[gi]  = stg_data_reg[gi-1];
      end

      if (gi < STAGES - 1) begin : g_plain
        always_ff @(posedge clk) begin
          if (rst) begin
            stg_valid_reg[gi] <= 1'b0;
            stg_mode_reg[gi]  <= 1'b0;
            stg_data_reg[gi]  <= '0;
          end else if (adv) begin
            stg_valid_reg[gi] <= feed_valid[gi];
            stg_mode_reg[gi]  <= feed_mode[gi];
            stg_data_reg[gi]  <= feed_data[gi];
          end
        end
      end else begin : g_output
        logic changed_next;
        logic drop_next;

        // Mode is deliberately excluded from the comparison.
        assign changed_next = !seen_reg | (feed_data[gi] != ref_reg);
        assign drop_next    = (CHANGE_ONLY != 0) && !changed_next;

        always_ff @(posedge clk) begin
          if (rst) begin
            stg_valid_reg[gi] <= 1'b0;
            stg_mode_reg[gi]  <= 1'b0;
            stg_data_reg[gi]  <= '0;
            changed_reg       <= 1'b0;
            first_reg         <= 1'b0;
            seen_reg          <= 1'b0;
            ref_reg           <= '0;
            drop_cnt_reg      <= '0;
          end else if (adv) begin
            if (feed_valid[gi] && drop_next) begin
              stg_valid_reg[gi] <= 1'b0;
              if (drop_cnt_reg != {CNT_W{1'b1}}) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
              end
            end else if (feed_valid[gi]) begin
              stg_valid_reg[gi] <= 1'b1;
              stg_mode_reg[gi]  <= feed_mode[gi];
              stg_data_reg[gi]  <= feed_data[gi];
              changed_reg       <= changed_next;
              first_reg         <= !seen_reg;
              seen_reg          <= 1'b1;
              ref_reg           <= feed_data[gi];
            end else begin
              stg_valid_reg[gi] <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  assign out_valid   = stg_valid_reg[STAGES-1];
  assign out_data    = stg_data_reg[STAGES-1];
  assign out_mode    = stg_mode_reg[STAGES-1];
  assign out_changed = changed_reg;
  assign out_first   = first_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench for gray_codec_pipe: unit A converts everything, unit B drops repeats with a 2-bit drop counter.
`timescale 1ns/1ps
module tb_gray_codec_pipe;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0;
  logic [W-1:0] a_in_data = '0, a_out_data;
  logic         a_out_valid, a_out_ready = 1'b1, a_out_mode, a_out_changed, a_out_first;
  logic [15:0]  a_drop_cnt;

  logic         b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0;
  logic [W-1:0] b_in_data = '0, b_out_data;
  logic         b_out_valid, b_out_ready = 1'b1, b_out_mode, b_out_changed, b_out_first;
  logic [1:0]   b_drop_cnt;

  gray_codec_pipe #(.WIDTH(W), .STAGES(2), .CHANGE_ONLY(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_mode(a_out_mode), .out_changed(a_out_changed), .out_first(a_out_first), .drop_cnt(a_drop_cnt)
  );

  gray_codec_pipe #(.WIDTH(W), .STAGES(3), .CHANGE_ONLY(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_mode(b_out_mode), .out_changed(b_out_changed), .out_first(b_out_first), .drop_cnt(b_drop_cnt)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         mode;
    logic         changed;
    logic         first;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  logic         a_seen = 1'b0, b_seen = 1'b0;
  logic [W-1:0] a_ref = '0, b_ref = '0;

  function automatic logic [W-1:0] b2g(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_a(input logic m, input logic [W-1:0] r);
    exp_t e;
    e.data    = r;
    e.mode    = m;
    e.first   = !a_seen;
    e.changed = !a_seen || (r != a_ref);
    a_seen    = 1'b1;
    a_ref     = r;
    qa.push_back(e);
  endfunction

  // Repeats are expected to vanish; the drop count itself is checked against constants.
  function automatic void push_b(input logic m, input logic [W-1:0] r);
    exp_t e;
    if (b_seen && r == b_ref) return;
    e.data    = r;
    e.mode    = m;
    e.first   = !b_seen;
    e.changed = 1'b1;
    b_seen    = 1'b1;
    b_ref     = r;
    qb.push_back(e);
  endfunction

  task automatic send_a(input logic m, input logic [W-1:0] d, input logic [W-1:0] r);
    logic ok;
    int   n;
    n = 0;
    a_in_valid = 1'b1; a_in_mode = m; a_in_data = d;
    do begin
      @(negedge clk); ok = a_in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 50);
    if (ok) push_a(m, r);
    else chk("send_a_timeout", 32'(n), 32'(0));
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic m, input logic [W-1:0] d, input logic [W-1:0] r);
    logic ok;
    int   n;
    n = 0;
    b_in_valid = 1'b1; b_in_mode = m; b_in_data = d;
    do begin
      @(negedge clk); ok = b_in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 50);
    if (ok) push_b(m, r);
    else chk("send_b_timeout", 32'(n), 32'(0));
    b_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("drain_qa_left", 32'(qa.size()), 32'(0));
    chk("drain_qb_left", 32'(qb.size()), 32'(0));
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Monitors: handshake rule, hold stability under stall, scoreboard pop on each transfer.
  exp_t a_hold, b_hold, a_cur, b_cur, e;
  logic a_holding = 1'b0, b_holding = 1'b0;

  always @(negedge clk) begin
    a_cur = '{a_out_data, a_out_mode, a_out_changed, a_out_first};
    b_cur = '{b_out_data, b_out_mode, b_out_changed, b_out_first};
    if (rst) begin
      a_holding = 1'b0;
      b_holding = 1'b0;
    end else begin
      chk("a_in_ready", 32'(a_in_ready), 32'(!a_out_valid || a_out_ready));
      chk("b_in_ready", 32'(b_in_ready), 32'(!b_out_valid || b_out_ready));
      if (a_holding) chk("a_hold", {27'd0, a_out_valid, a_cur}, {27'd1, a_hold});
      if (b_holding) chk("b_hold", {27'd0, b_out_valid, b_cur}, {27'd1, b_hold});
      a_holding = a_out_valid && !a_out_ready; a_hold = a_cur;
      b_holding = b_out_valid && !b_out_ready; b_hold = b_cur;
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_unexpected_out", 32'(a_cur), 32'hFFFF_FFFF);
        else begin
          e = qa.pop_front();
          chk("a_out {data,mode,changed,first}", 32'(a_cur), 32'(e));
          $display("A out data=%b mode=%0d changed=%0d first=%0d", a_out_data, a_out_mode, a_out_changed, a_out_first);
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_unexpected_out", 32'(b_cur), 32'hFFFF_FFFF);
        else begin
          e = qb.pop_front();
          chk("b_out {data,mode,changed,first}", 32'(b_cur), 32'(e));
          $display("B out data=%b mode=%0d changed=%0d first=%0d", b_out_data, b_out_mode, b_out_changed, b_out_first);
        end
      end
    end
  end

  // {mode, data in, expected result}
  logic [8:0] vec_a [8];
  logic [8:0] v;
  logic [3:0] vec_b [6];

  initial begin
    vec_a[0] = {1'b1, 4'b1110, 4'b1011};
    vec_a[1] = {1'b0, 4'b0000, 4'b0000};
    vec_a[2] = {1'b0, 4'b1111, 4'b1000};
    vec_a[3] = {1'b1, 4'b1000, 4'b1111};
    vec_a[4] = {1'b0, 4'b0011, 4'b0010};
    vec_a[5] = {1'b1, 4'b0011, 4'b0010};
    vec_a[6] = {1'b0, 4'b0110, 4'b0101};
    vec_a[7] = {1'b1, 4'b0101, 4'b0110};
    vec_b[0] = 4'd3; vec_b[1] = 4'd3; vec_b[2] = 4'd3;
    vec_b[3] = 4'd5; vec_b[4] = 4'd5; vec_b[5] = 4'd3;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_data", 32'(a_out_data), 0);
    chk("rst_a_flags", {29'd0, a_out_mode, a_out_changed, a_out_first}, 0);
    chk("rst_b_valid", 32'(b_out_valid), 0);
    chk("rst_b_drop", 32'(b_drop_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: latency and first-result flags
    send_a(1'b0, 4'b1011, 4'b1110);
    @(negedge clk);
    chk("t1_valid_cycle1", 32'(a_out_valid), 0);
    @(negedge clk);
    chk("t1_valid_cycle2", 32'(a_out_valid), 1);
    chk("t1_data", 32'(a_out_data), 32'(4'b1110));
    chk("t1_first_changed", {30'd0, a_out_first, a_out_changed}, 32'b11);
    @(posedge clk); #1;

    // T2: directed codes both ways, then full sweep with round trip
    for (int i = 0; i < 8; i++) begin
      v = vec_a[i];
      send_a(v[8], v[7:4], v[3:0]);
    end
    for (int i = 0; i < 16; i++) begin
      send_a(1'b0, 4'(i), b2g(4'(i)));
      send_a(1'b1, b2g(4'(i)), 4'(i));
    end
    wait_drain();

    // T3: 8-word back-to-back burst with a 3-cycle output stall
    fork
      for (int i = 0; i < 8; i++) send_a(1'b0, 4'(i * 3 + 1), b2g(4'(i * 3 + 1)));
      begin
        repeat (3) @(posedge clk); #1;
        a_out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("a_drop_cnt_zero", 32'(a_drop_cnt), 0);

    // T4: bin 3,3,3,5,5,3 -> gray 2,7,2, three drops
    for (int i = 0; i < 6; i++) send_b(1'b0, vec_b[i], b2g(vec_b[i]));
    wait_drain();
    chk("t4_drop_cnt", 32'(b_drop_cnt), 3);

    // T5: more repeats (one in the other mode) saturate the 2-bit counter
    for (int i = 0; i < 6; i++) send_b(1'b0, 4'd3, 4'd2);
    send_b(1'b1, 4'd3, 4'd2);
    wait_drain();
    chk("t5_drop_sat", 32'(b_drop_cnt), 3);

    // T6: reset with two words in flight
    send_a(1'b0, 4'd1, 4'd1);
    send_a(1'b0, 4'd2, 4'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    qa.delete(); qb.delete();
    a_seen = 1'b0; b_seen = 1'b0; a_ref = '0; b_ref = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(a_out_valid), 0);
    chk("t6_drop_after_rst", 32'(b_drop_cnt), 0);
    @(posedge clk); #1;
    send_a(1'b0, 4'd5, 4'd7);
    send_b(1'b0, 4'd5, 4'd7);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
